// File: rtl/ysyx_25020037_wbu.sv
// Write-back stage: retires one instruction, waits for the load response, aligns/extends load data, emits a one-cycle commit.
// Latency: non-load accepted in cycle N commits in N+1; a load whose response arrives in cycle M commits in M+1.
// Backpressure: wbu_ready drops only while waiting for a load response; COMMIT accepts a new instruction in the same cycle.
// Ports: lsu_valid/wbu_ready + in_* carry the instruction in; mem_rvalid/mem_rready/mem_rdata/mem_rresp carry the load
// response; wbu_valid qualifies rd/gpr_*/csr_*/ecall_en/mret_en/commit_pc/load_fault; retire_cnt counts commits.
module ysyx_25020037_wbu #(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 4,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               lsu_valid,
  output logic               wbu_ready,
  input  logic [XLEN-1:0]    in_pc,
  input  logic [RADDR_W-1:0] in_rd,
  input  logic               in_gpr_wen,
  input  logic [XLEN-1:0]    in_alu_result,
  input  logic               in_is_load,
  input  logic [1:0]         in_load_size,
  input  logic               in_load_unsigned,
  input  logic [1:0]         in_addr_lo,
  input  logic [1:0]         in_csr_op,
  input  logic [2:0]         in_csr_sel,
  input  logic [XLEN-1:0]    in_csr_old,
  input  logic [XLEN-1:0]    in_csr_src,
  input  logic               in_ecall,
  input  logic               in_mret,
  input  logic               mem_rvalid,
  input  logic [XLEN-1:0]    mem_rdata,
  input  logic [1:0]         mem_rresp,
  output logic               mem_rready,
  output logic               wbu_valid,
  output logic [RADDR_W-1:0] rd,
  output logic               gpr_wen,
  output logic [XLEN-1:0]    gpr_wdata,
  output logic [2:0]         csr_wen,
  output logic [XLEN-1:0]    csr_wdata,
  output logic               ecall_en,
  output logic               mret_en,
  output logic [XLEN-1:0]    commit_pc,
  output logic               load_fault,
  output logic [CNT_W-1:0]   retire_cnt
);

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT_MEM = 2'd1, COMMIT = 2'd2} state_t;

  state_t state, next_state;
  logic   accept, from_mem, commit_load;

  // Instruction fields held while a load response is outstanding.
  logic [XLEN-1:0]    c_pc, c_csr_old, c_csr_src;
  logic [RADDR_W-1:0] c_rd;
  logic               c_gpr_wen, c_load_unsigned, c_ecall, c_mret;
  logic [1:0]         c_load_size, c_addr_lo, c_csr_op;
  logic [2:0]         c_csr_sel;

  // Fields of the instruction that commits next: captured copy for loads, live inputs otherwise.
  logic [XLEN-1:0]    s_pc, s_csr_old, s_csr_src;
  logic [RADDR_W-1:0] s_rd;
  logic               s_gpr_wen, s_ecall, s_mret;
  logic [1:0]         s_csr_op;
  logic [2:0]         s_csr_sel;

  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [XLEN-1:0] ld_data, n_gpr_wdata, n_csr_wdata;
  logic            fault;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE:     if (accept) next_state = in_is_load ? WAIT_MEM : COMMIT;
      WAIT_MEM: if (mem_rvalid) next_state = COMMIT;
      COMMIT:   next_state = accept ? (in_is_load ? WAIT_MEM : COMMIT) : IDLE;
      default:  next_state = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    wbu_ready  = (state != WAIT_MEM);
    mem_rready = (state == WAIT_MEM);
    wbu_valid  = (state == COMMIT);
  end

  assign accept      = lsu_valid & wbu_ready;
  assign from_mem    = (state == WAIT_MEM);
  // Entering COMMIT is exactly the cycle whose values must appear on the commit outputs next cycle.
  assign commit_load = (next_state == COMMIT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      c_pc <= '0; c_rd <= '0; c_gpr_wen <= 1'b0; c_load_size <= '0; c_load_unsigned <= 1'b0;
      c_addr_lo <= '0; c_csr_op <= '0; c_csr_sel <= '0; c_csr_old <= '0; c_csr_src <= '0;
      c_ecall <= 1'b0; c_mret <= 1'b0;
    end else if (accept) begin
      c_pc <= in_pc; c_rd <= in_rd; c_gpr_wen <= in_gpr_wen; c_load_size <= in_load_size;
      c_load_unsigned <= in_load_unsigned; c_addr_lo <= in_addr_lo; c_csr_op <= in_csr_op;
      c_csr_sel <= in_csr_sel; c_csr_old <= in_csr_old; c_csr_src <= in_csr_src;
      c_ecall <= in_ecall; c_mret <= in_mret;
    end
  end

  always_comb begin
    s_pc      = from_mem ? c_pc      : in_pc;
    s_rd      = from_mem ? c_rd      : in_rd;
    s_gpr_wen = from_mem ? c_gpr_wen : in_gpr_wen;
    s_csr_op  = from_mem ? c_csr_op  : in_csr_op;
    s_csr_sel = from_mem ? c_csr_sel : in_csr_sel;
    s_csr_old = from_mem ? c_csr_old : in_csr_old;
    s_csr_src = from_mem ? c_csr_src : in_csr_src;
    s_ecall   = from_mem ? c_ecall   : in_ecall;
    s_mret    = from_mem ? c_mret    : in_mret;
  end

  // Load alignment; half-word low address bit is ignored since upstream keeps halves aligned.
  always_comb begin
    ld_byte = '0;
    case (c_addr_lo)
      2'd0:    ld_byte = mem_rdata[7:0];
      2'd1:    ld_byte = mem_rdata[15:8];
      2'd2:    ld_byte = mem_rdata[23:16];
      default: ld_byte = mem_rdata[31:24];
    endcase
    ld_half = c_addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (c_load_size)
      2'b00:   ld_data = {{(XLEN-8){~c_load_unsigned & ld_byte[7]}}, ld_byte};
      2'b01:   ld_data = {{(XLEN-16){~c_load_unsigned & ld_half[15]}}, ld_half};
      default: ld_data = mem_rdata;
    endcase
  end

  assign fault = from_mem & (mem_rresp != 2'b00);

  always_comb begin
    if (from_mem)              n_gpr_wdata = ld_data;
    else if (s_csr_op != 2'b0) n_gpr_wdata = s_csr_old;
    else                       n_gpr_wdata = in_alu_result;

    // No CSR op and no ecall: keep the last CSR data so the bus does not toggle needlessly.
    n_csr_wdata = csr_wdata;
    case (s_csr_op)
      2'b01:   n_csr_wdata = s_csr_src;
      2'b10:   n_csr_wdata = s_csr_old | s_csr_src;
      2'b11:   n_csr_wdata = s_csr_old & ~s_csr_src;
      default: n_csr_wdata = csr_wdata;
    endcase
    // ecall writes the trapping PC to mepc and takes precedence over any CSR op.
    if (s_ecall) n_csr_wdata = s_pc;
  end

  // Commit outputs: data fields hold between commits, enables are high only in the commit cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd <= '0; gpr_wdata <= '0; csr_wdata <= '0; commit_pc <= '0;
      gpr_wen <= 1'b0; csr_wen <= '0; ecall_en <= 1'b0; mret_en <= 1'b0; load_fault <= 1'b0;
    end else begin
      if (commit_load) begin
        rd        <= s_rd;
        gpr_wdata <= n_gpr_wdata;
        csr_wdata <= n_csr_wdata;
        commit_pc <= s_pc;
      end
      gpr_wen    <= commit_load & s_gpr_wen & (s_rd != '0) & ~fault;
      csr_wen    <= (commit_load && s_csr_op != 2'b00) ? s_csr_sel : 3'b000;
      ecall_en   <= commit_load & s_ecall;
      mret_en    <= commit_load & s_mret;
      load_fault <= commit_load & fault;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                 retire_cnt <= '0;
    else if (state == COMMIT) retire_cnt <= retire_cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_ysyx_25020037_wbu.sv
module tb_ysyx_25020037_wbu;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic lsu_valid, wbu_ready, in_gpr_wen, in_is_load, in_load_unsigned, in_ecall, in_mret;
  logic [31:0] in_pc, in_alu_result, in_csr_old, in_csr_src, mem_rdata;
  logic [3:0] in_rd;
  logic [1:0] in_load_size, in_addr_lo, in_csr_op, mem_rresp;
  logic [2:0] in_csr_sel;
  logic mem_rvalid, mem_rready, wbu_valid, gpr_wen, ecall_en, mret_en, load_fault;
  logic [3:0] rd;
  logic [31:0] gpr_wdata, csr_wdata, commit_pc, retire_cnt;
  logic [2:0] csr_wen;

  ysyx_25020037_wbu dut (
    .clk(clk), .rst(rst), .lsu_valid(lsu_valid), .wbu_ready(wbu_ready), .in_pc(in_pc), .in_rd(in_rd),
    .in_gpr_wen(in_gpr_wen), .in_alu_result(in_alu_result), .in_is_load(in_is_load),
    .in_load_size(in_load_size), .in_load_unsigned(in_load_unsigned), .in_addr_lo(in_addr_lo),
    .in_csr_op(in_csr_op), .in_csr_sel(in_csr_sel), .in_csr_old(in_csr_old), .in_csr_src(in_csr_src),
    .in_ecall(in_ecall), .in_mret(in_mret), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .mem_rresp(mem_rresp), .mem_rready(mem_rready), .wbu_valid(wbu_valid), .rd(rd), .gpr_wen(gpr_wen),
    .gpr_wdata(gpr_wdata), .csr_wen(csr_wen), .csr_wdata(csr_wdata), .ecall_en(ecall_en),
    .mret_en(mret_en), .commit_pc(commit_pc), .load_fault(load_fault), .retire_cnt(retire_cnt)
  );

  typedef struct {
    logic [31:0] pc, alu, old, src;
    logic [3:0]  rd;
    logic        gw, ld, us, ec, mr;
    logic [1:0]  sz, al, op;
    logic [2:0]  sel;
  } ins_t;

  typedef struct {
    logic [3:0]  rd;
    logic        gw, gd_chk, cd_chk, ec, mr, lf;
    logic [31:0] gd, cd, pc;
    logic [2:0]  cw;
    int          due;
  } exp_t;

  exp_t q[$];
  int n_checks = 0, n_errors = 0;
  int ncyc = 0, model_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: commit expected from an instruction and its (optional) read response.
  function automatic exp_t model(input ins_t i, input logic [31:0] rdata, input logic [1:0] rresp);
    exp_t e;
    logic [31:0] v;
    e.rd = i.rd; e.pc = i.pc; e.ec = i.ec; e.mr = i.mr; e.due = 0;
    e.lf = i.ld && (rresp != 2'b00);
    if (i.ld) begin
      if (i.sz == 2'd0) begin
        v = (rdata >> (8 * i.al)) & 32'hFF;
        if (!i.us && v >= 32'd128) v = v + 32'hFFFF_FF00;
      end else if (i.sz == 2'd1) begin
        v = (rdata >> (16 * i.al[1])) & 32'hFFFF;
        if (!i.us && v >= 32'd32768) v = v + 32'hFFFF_0000;
      end else v = rdata;
    end else if (i.op != 2'd0) v = i.old;
    else v = i.alu;
    e.gd = v;
    e.gd_chk = !e.lf;
    e.gw = i.gw && (i.rd != 0) && !e.lf;
    e.cw = (i.op != 2'd0) ? i.sel : 3'b000;
    case (i.op)
      2'd1: e.cd = i.src;
      2'd2: e.cd = i.old | i.src;
      2'd3: e.cd = i.old & ~i.src;
      default: e.cd = 32'h0;
    endcase
    if (i.ec) e.cd = i.pc;
    e.cd_chk = i.ec || (i.op != 2'd0);
    return e;
  endfunction

  function automatic ins_t blank();
    ins_t i;
    i.pc = 32'h8000_0000; i.alu = 0; i.old = 0; i.src = 0; i.rd = 0; i.gw = 0; i.ld = 0;
    i.us = 0; i.ec = 0; i.mr = 0; i.sz = 0; i.al = 0; i.op = 0; i.sel = 0;
    return i;
  endfunction

  function automatic ins_t rand_ins(input logic ld);
    ins_t i;
    int kind;
    i = blank();
    i.pc = $urandom & 32'hFFFF_FFFC; i.alu = $urandom; i.old = $urandom; i.src = $urandom;
    i.rd = 4'($urandom_range(0, 15)); i.gw = 1'($urandom_range(0, 1)); i.ld = ld;
    if (ld) begin
      i.sz = 2'($urandom_range(0, 2)); i.us = 1'($urandom_range(0, 1)); i.al = 2'($urandom_range(0, 3));
      if (i.sz == 2'd1) i.al[0] = 1'b0;
    end else begin
      kind = $urandom_range(0, 9);
      if (kind == 0) i.ec = 1'b1;
      else if (kind == 1) i.mr = 1'b1;
      else if (kind < 6) begin
        i.op = 2'($urandom_range(1, 3));
        i.sel = 3'b001 << $urandom_range(0, 2);
      end
    end
    return i;
  endfunction

  task automatic scramble_inputs();
    in_pc = $urandom; in_rd = 4'($urandom); in_gpr_wen = 1'($urandom); in_alu_result = $urandom;
    in_is_load = 1'($urandom); in_load_size = 2'($urandom); in_load_unsigned = 1'($urandom);
    in_addr_lo = 2'($urandom); in_csr_op = 2'($urandom); in_csr_sel = 3'($urandom);
    in_csr_old = $urandom; in_csr_src = $urandom; in_ecall = 1'($urandom); in_mret = 1'($urandom);
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic drive(input ins_t i);
    exp_t e;
    in_pc = i.pc; in_rd = i.rd; in_gpr_wen = i.gw; in_alu_result = i.alu; in_is_load = i.ld;
    in_load_size = i.sz; in_load_unsigned = i.us; in_addr_lo = i.al; in_csr_op = i.op;
    in_csr_sel = i.sel; in_csr_old = i.old; in_csr_src = i.src; in_ecall = i.ec; in_mret = i.mr;
    lsu_valid = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (wbu_ready === 1'b1) break;
    end
    if (wbu_ready !== 1'b1) check("ready_wait", wbu_ready, 1);
    @(posedge clk);
    if (!i.ld) begin
      e = model(i, 32'h0, 2'b00);
      e.due = ncyc + 1;
      q.push_back(e);
    end
    #1;
    lsu_valid = 1'b0;
    scramble_inputs();
  endtask

  task automatic respond(input ins_t i, input int delay, input logic [31:0] rdata, input logic [1:0] rresp);
    exp_t e;
    for (int d = 0; d < delay; d++) begin
      @(negedge clk);
      check("wait_ready_low", wbu_ready, 0);
      check("wait_rready", mem_rready, 1);
      @(posedge clk); #1;
    end
    mem_rvalid = 1'b1; mem_rdata = rdata; mem_rresp = rresp;
    @(posedge clk);
    e = model(i, rdata, rresp);
    e.due = ncyc + 1;
    q.push_back(e);
    #1;
    mem_rvalid = 1'b0; mem_rdata = $urandom; mem_rresp = 2'($urandom);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b1) begin
      ncyc++;
      check("retire_cnt", retire_cnt, model_cnt);
      if (wbu_valid === 1'b1) begin
        if (q.size() == 0) check("spurious_commit", wbu_valid, 0);
        else begin
          e = q.pop_front();
          check("latency", ncyc, e.due);
          check("rd", rd, e.rd);
          check("gpr_wen", gpr_wen, e.gw);
          if (e.gd_chk) check("gpr_wdata", gpr_wdata, e.gd);
          check("csr_wen", csr_wen, e.cw);
          if (e.cd_chk) check("csr_wdata", csr_wdata, e.cd);
          check("ecall_en", ecall_en, e.ec);
          check("mret_en", mret_en, e.mr);
          check("commit_pc", commit_pc, e.pc);
          check("load_fault", load_fault, e.lf);
          model_cnt++;
        end
      end else begin
        check("idle_enables", {gpr_wen, csr_wen, ecall_en, mret_en, load_fault}, 0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    ins_t i;
    rst = 1'b0; lsu_valid = 1'b0; mem_rvalid = 1'b0; mem_rdata = 0; mem_rresp = 0;
    scramble_inputs();
    #1;
    check("rst_valid", wbu_valid, 0);
    check("rst_rready", mem_rready, 0);
    check("rst_cnt", retire_cnt, 0);
    check("rst_wdata", gpr_wdata, 0);
    check("rst_pc", commit_pc, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    // addi x3 <- 5
    i = blank(); i.alu = 32'h5; i.rd = 4'd3; i.gw = 1'b1;
    drive(i);
    @(negedge clk);
    check("t1_valid", wbu_valid, 1); check("t1_rd", rd, 3);
    check("t1_wen", gpr_wen, 1); check("t1_wdata", gpr_wdata, 32'h5);
    @(negedge clk);
    check("t1_valid_low", wbu_valid, 0); check("t1_cnt", retire_cnt, 1);
    @(posedge clk); #1;

    // lb / lbu / lhu at addr_lo=2
    i = blank(); i.ld = 1'b1; i.rd = 4'd4; i.gw = 1'b1; i.al = 2'd2; i.sz = 2'd0;
    drive(i); respond(i, 4, 32'h1280_3456, 2'b00);
    @(negedge clk); check("lb_data", gpr_wdata, 32'hFFFF_FF80);
    @(posedge clk); #1;
    i.us = 1'b1;
    drive(i); respond(i, 2, 32'h1280_3456, 2'b00);
    @(negedge clk); check("lbu_data", gpr_wdata, 32'h0000_0080);
    @(posedge clk); #1;
    i.sz = 2'd1;
    drive(i); respond(i, 1, 32'h1280_3456, 2'b00);
    @(negedge clk); check("lhu_data", gpr_wdata, 32'h0000_1280);
    @(posedge clk); #1;

    // csrrs / csrrc on mstatus
    i = blank(); i.rd = 4'd6; i.gw = 1'b1; i.op = 2'd2; i.old = 32'h1800; i.src = 32'h8; i.sel = 3'b001;
    drive(i);
    @(negedge clk);
    check("csrrs_gpr", gpr_wdata, 32'h1800); check("csrrs_csr", csr_wdata, 32'h1808);
    check("csrrs_wen", csr_wen, 3'b001);
    @(posedge clk); #1;
    i.op = 2'd3;
    drive(i);
    @(negedge clk); check("csrrc_csr", csr_wdata, 32'h1800);
    @(posedge clk); #1;

    // ecall, mret
    i = blank(); i.pc = 32'h8000_0100; i.ec = 1'b1;
    drive(i);
    @(negedge clk);
    check("ecall_en", ecall_en, 1); check("ecall_mepc", csr_wdata, 32'h8000_0100);
    check("ecall_gwen", gpr_wen, 0); check("ecall_cwen", csr_wen, 0);
    @(posedge clk); #1;
    i = blank(); i.mr = 1'b1;
    drive(i);
    @(negedge clk);
    check("mret_en", mret_en, 1); check("mret_ecall", ecall_en, 0); check("mret_cwen", csr_wen, 0);
    @(posedge clk); #1;

    // faulting load, write to x0
    i = blank(); i.ld = 1'b1; i.rd = 4'd5; i.gw = 1'b1; i.sz = 2'd2;
    drive(i); respond(i, 3, 32'hDEAD_BEEF, 2'b10);
    @(negedge clk);
    check("fault_valid", wbu_valid, 1); check("fault_flag", load_fault, 1); check("fault_gwen", gpr_wen, 0);
    @(posedge clk); #1;
    i = blank(); i.rd = 4'd0; i.gw = 1'b1; i.alu = 32'h77;
    drive(i);
    @(negedge clk); check("x0_gwen", gpr_wen, 0);
    @(posedge clk); #1;

    // back-to-back non-loads: latency check in the monitor forces consecutive commits
    for (int k = 0; k < 6; k++) drive(rand_ins(1'b0));
    @(negedge clk); @(negedge clk);
    check("b2b_drain", q.size(), 0);
    @(posedge clk); #1;

    // reset while waiting for a load response
    i = rand_ins(1'b1);
    drive(i);
    @(negedge clk); @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("arst_valid", wbu_valid, 0); check("arst_rready", mem_rready, 0);
    check("arst_cnt", retire_cnt, 0); check("arst_wdata", gpr_wdata, 0);
    check("arst_rd", rd, 0); check("arst_pc", commit_pc, 0); check("arst_csr", csr_wdata, 0);
    model_cnt = 0;
    @(posedge clk); #1 rst = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = $urandom; mem_rresp = 2'b00;
    @(posedge clk); #1 mem_rvalid = 1'b0;
    @(negedge clk); check("arst_no_commit", wbu_valid, 0);
    @(negedge clk); check("arst_no_commit2", wbu_valid, 0);
    @(posedge clk); #1;

    // randomized traffic with gaps and stray read responses
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        i = rand_ins(1'b1);
        drive(i);
        respond(i, $urandom_range(0, 5), $urandom, ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00);
      end else begin
        drive(rand_ins(1'b0));
      end
      case ($urandom_range(0, 5))
        0: begin @(posedge clk); #1; end
        1: begin
          mem_rvalid = 1'b1; mem_rdata = $urandom; mem_rresp = 2'b00;
          @(posedge clk); #1 mem_rvalid = 1'b0;
        end
        default: ;
      endcase
    end

    repeat (3) @(negedge clk);
    check("final_drain", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/ysyx_25020037_wbu.md
Name: ysyx_25020037_wbu

Overview:
Write-back stage of the RV32E multi-cycle core. It sits between the load/store stage and the GPR/CSR register file. It accepts one retiring instruction over a valid/ready handshake and, for loads, waits for the memory read response, then aligns and extends the data. It then presents a single-cycle commit (wbu_valid) carrying the GPR write, CSR write, ecall and mret controls consumed by the register file.

Parameters:
XLEN, 32, datapath width
RADDR_W, 4, GPR index width (16 registers)
CNT_W, 32, retire counter width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
lsu_valid  in  1  upstream instruction valid
wbu_ready  out  1  stage can accept an instruction this cycle
in_pc  in  32  PC of the instruction
in_rd  in  4  destination GPR
in_gpr_wen  in  1  instruction writes a GPR
in_alu_result  in  32  ALU/address result
in_is_load  in  1  instruction is a load
in_load_size  in  2  00 byte, 01 half, 10 word
in_load_unsigned  in  1  zero-extend the loaded value
in_addr_lo  in  2  load address bits [1:0]
in_csr_op  in  2  00 none, 01 write, 10 set, 11 clear
in_csr_sel  in  3  one-hot {mtvec, mepc, mstatus} write target
in_csr_old  in  32  CSR read value
in_csr_src  in  32  rs1 or zimm operand
in_ecall  in  1  ecall
in_mret  in  1  mret
mem_rvalid  in  1  read response valid
mem_rdata  in  32  read data
mem_rresp  in  2  00 OKAY; anything else is an error
mem_rready  out  1  ready for read response
wbu_valid  out  1  commit pulse
rd  out  4  committed destination
gpr_wen  out  1  GPR write enable
gpr_wdata  out  32  GPR write data
csr_wen  out  3  one-hot CSR write enables {mtvec, mepc, mstatus}
csr_wdata  out  32  CSR write data
ecall_en  out  1  ecall commit
mret_en  out  1  mret commit
commit_pc  out  32  PC of the committed instruction
load_fault  out  1  committed load had an error response
retire_cnt  out  CNT_W  number of committed instructions

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; all outputs 0; retire_cnt=0. A read response in flight during reset is dropped.
- States:
  - IDLE: wbu_ready=1, mem_rready=0.
  - WAIT_MEM: wbu_ready=0, mem_rready=1.
  - COMMIT: wbu_valid=1 for exactly one cycle; wbu_ready=1, so a new instruction can be accepted in the same cycle.
- Accept condition: lsu_valid & wbu_ready. All in_* fields are captured on accept.
  - Next state WAIT_MEM if in_is_load, else COMMIT.
  - No accept from COMMIT: next state IDLE.
- WAIT_MEM: on mem_rvalid the stage captures rdata/rresp and moves to COMMIT. Otherwise it stays in WAIT_MEM indefinitely; there is no timeout.
- Latency:
  - Non-load accepted in cycle N: wbu_valid in cycle N+1.
  - Load: response in cycle M: wbu_valid in cycle M+1.
  - Peak throughput: one non-load per cycle.
- Load alignment and extension:
  - Byte: rdata[8*addr_lo +: 8].
  - Half: rdata[16*addr_lo[1] +: 16]; addr_lo[0] is ignored because upstream guarantees alignment.
  - Word: full rdata; addr_lo is ignored.
  - Sign-extend unless in_load_unsigned=1.
- gpr_wdata source priority: load data, then in_csr_old when csr_op≠00, then in_alu_result.
- CSR write data:
  - op 01: src.
  - op 10: old|src.
  - op 11: old&~src.
  - csr_wen = in_csr_sel when op≠00, else 000.
- ecall: ecall_en=1 and csr_wdata=in_pc (mepc capture). csr_wen is not asserted by the ecall itself.
- mret: mret_en=1.
- Qualification rules:
  - gpr_wen = in_gpr_wen & (rd≠0) & ~load_fault.
  - On a load error, load_fault=1 and no GPR write occurs.
  - gpr_wen, csr_wen, ecall_en, mret_en and load_fault are 0 whenever wbu_valid=0.
  - rd, gpr_wdata, csr_wdata and commit_pc hold their last value.
- retire_cnt increments by 1 on every wbu_valid cycle, including faulting loads, and wraps to 0.
- Simultaneous events:
  - ecall and csr_op≠00 together never arrive from upstream; if they do, ecall's csr_wdata wins.
  - A mem_rvalid outside WAIT_MEM is ignored.

Test Plan:
1. addi result 0x0000_0005, rd=3, accepted in cycle 10 -> cycle 11: wbu_valid=1, rd=3, gpr_wen=1, gpr_wdata=5; cycle 12: wbu_valid=0; retire_cnt=1.
2. lb, addr_lo=2, rdata=0x1280_3456, response delayed 4 cycles -> wbu_ready=0 while waiting; one cycle after rvalid, gpr_wdata=0xFFFF_FF80. Repeat with lbu -> 0x0000_0080. lhu with addr_lo=2 -> 0x0000_1280.
3. csrrs with old=0x1800, src=0x8, sel=mstatus -> gpr_wdata=0x1800, csr_wdata=0x1808, csr_wen=001. csrrc with the same operands -> csr_wdata=0x1800.
4. ecall at pc=0x8000_0100 -> ecall_en=1, csr_wdata=0x8000_0100, gpr_wen=0. mret -> mret_en=1 only.
5. Load with rresp=10, rd=5 -> wbu_valid=1, load_fault=1, gpr_wen=0, retire_cnt increments. Write to rd=0 -> gpr_wen=0.
6. Back-to-back non-loads on consecutive cycles -> wbu_valid high on consecutive cycles. Drive rst low while in WAIT_MEM -> outputs go to 0 immediately; a following mem_rvalid produces no commit.
